// File: rtl/seq_mult_ctrl_if.sv
// Handshake and datapath-strobe bundle between a requester/datapath and the
// sequential shift-add multiplier controller. WIDTH must match the controller.
interface seq_mult_ctrl_if #(
    parameter int WIDTH = 4
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    // request side and datapath status
    logic             start;
    logic             lsb;
    logic             mult_zero;

    // controller status
    logic             ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] iter_cnt;

    // datapath strobes
    logic             sig_rst;
    logic             ld1;
    logic             ld2;
    logic             sel_add;
    logic             shift;

    // requester / datapath view
    modport master (
        output start,
        output lsb,
        output mult_zero,
        input  ready,
        input  busy,
        input  done,
        input  iter_cnt,
        input  sig_rst,
        input  ld1,
        input  ld2,
        input  sel_add,
        input  shift
    );

    // controller view
    modport slave (
        input  start,
        input  lsb,
        input  mult_zero,
        output ready,
        output busy,
        output done,
        output iter_cnt,
        output sig_rst,
        output ld1,
        output ld2,
        output sel_add,
        output shift
    );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Control unit for a WIDTH-bit sequential shift-add multiplier.
// Sequences clear / load / WIDTH add-shift iterations / done, with a
// start/ready handshake and a one-cycle done pulse.
// Optional macro SEQ_MULT_CTRL_EARLY_TERM_EN: leave EXEC as soon as the
// datapath reports that the remaining multiplier bits are all zero.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready, waiting for start
// CLEAR | clear accumulator, preload iteration counter with WIDTH
// LOAD  | load multiplicand and multiplier registers
// EXEC  | one add(if lsb)/shift iteration per cycle, counter decrements
// DONE  | one-cycle done pulse, product valid in accumulator
module seq_mult_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    seq_mult_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_EXEC  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t           state_q;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             early_term;

    logic             ready_c;
    logic             sig_rst_c;
    logic             ld1_c;
    logic             ld2_c;
    logic             sel_add_c;
    logic             shift_c;
    logic             done_c;

`ifdef SEQ_MULT_CTRL_EARLY_TERM_EN
    // Accumulator is never shifted, so stopping once no set bits remain
    // leaves the product already complete.
    assign early_term = bus.mult_zero;
`else
    logic unused_mult_zero;
    assign unused_mult_zero = bus.mult_zero;
    assign early_term       = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Iteration down-counter: preload in CLEAR, decrement per EXEC, stop at 0
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CNT_ZERO;
        end else if (state_q == S_CLEAR) begin
            cnt_q <= CNT_INIT;
        end else if ((state_q == S_EXEC) && (cnt_q != CNT_ZERO)) begin
            cnt_q <= cnt_q - CNT_ONE;
        end
    end

    // Next-state and Moore strobe decode (sel_add also follows lsb in EXEC)
    always_comb begin
        state_nxt = state_q;
        ready_c   = 1'b0;
        sig_rst_c = 1'b0;
        ld1_c     = 1'b0;
        ld2_c     = 1'b0;
        sel_add_c = 1'b0;
        shift_c   = 1'b0;
        done_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_c = 1'b1;
                if (bus.start) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                sig_rst_c = 1'b1;
                state_nxt = S_LOAD;
            end
            S_LOAD: begin
                ld1_c     = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                ld2_c     = 1'b1;
                shift_c   = 1'b1;
                sel_add_c = bus.lsb;
                // <= rather than == so a corrupted zero count cannot hang here
                if ((cnt_q <= CNT_ONE) || early_term) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done_c    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.ready    = ready_c;
    assign bus.busy     = ~ready_c;
    assign bus.sig_rst  = sig_rst_c;
    assign bus.ld1      = ld1_c;
    assign bus.ld2      = ld2_c;
    assign bus.sel_add  = sel_add_c;
    assign bus.shift    = shift_c;
    assign bus.done     = done_c;
    assign bus.iter_cnt = cnt_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench for seq_mult_ctrl: directed table on a WIDTH=4 instance, hand
// sequences for held start and early termination on a WIDTH=8 instance,
// then random stimulus on both against a cycle-offset reference model.
module tb_seq_mult_ctrl;

`ifdef SEQ_MULT_CTRL_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst4;
    logic rst8;

    int n_cmp = 0;
    int n_err = 0;

    seq_mult_ctrl_if #(.WIDTH(4)) bus4 ();
    seq_mult_ctrl_if #(.WIDTH(8)) bus8 ();

    seq_mult_ctrl #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst4), .bus(bus4));
    seq_mult_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst8), .bus(bus8));

    always #5 clk = ~clk;

    // {ready, busy, sig_rst, ld1, ld2, sel_add, shift, done}
    logic [7:0] act4;
    logic [7:0] act8;
    assign act4 = {bus4.ready, bus4.busy, bus4.sig_rst, bus4.ld1,
                   bus4.ld2, bus4.sel_add, bus4.shift, bus4.done};
    assign act8 = {bus8.ready, bus8.busy, bus8.sig_rst, bus8.ld1,
                   bus8.ld2, bus8.sel_add, bus8.shift, bus8.done};

    // Phase k = cycles since start acceptance (0 = idle):
    // 1 clear, 2 load, 3..w+2 exec, w+3 done.
    function automatic logic [7:0] exp_out(input int w, input int k, input bit l);
        bit ex;
        ex = (k >= 3) && (k <= w + 2);
        return {k == 0, k != 0, k == 1, k == 2, ex, ex && l, ex, k == w + 3};
    endfunction

    function automatic void model_step(input int w, input bit r, input bit s,
                                       input bit mz, input int k_in, input int c_in,
                                       output int k_out, output int c_out);
        k_out = k_in;
        c_out = c_in;
        if (r) begin
            k_out = 0;
            c_out = 0;
        end else if (k_in == 0) begin
            if (s) k_out = 1;
        end else if (k_in == 1) begin
            k_out = 2;
            c_out = w;
        end else if (k_in == 2) begin
            k_out = 3;
        end else if (k_in <= w + 2) begin
            c_out = (c_in > 0) ? c_in - 1 : 0;
            k_out = ((k_in == w + 2) || (EARLY && mz)) ? w + 3 : k_in + 1;
        end else begin
            k_out = 0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit rst;
        bit start;
        bit lsb;
        int k;
        int cnt;
    } row_t;

    row_t tbl[$];

    function automatic row_t mk(input bit r, input bit s, input bit l, input int k, input int c);
        row_t t;
        t.rst = r; t.start = s; t.lsb = l; t.k = k; t.cnt = c;
        return t;
    endfunction

    task automatic reset_all();
        @(negedge clk);
        rst4 = 1'b1; rst8 = 1'b1;
        bus4.start = 1'b0; bus4.lsb = 1'b0; bus4.mult_zero = 1'b0;
        bus8.start = 1'b0; bus8.lsb = 1'b0; bus8.mult_zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_done;
        int cnt_at_done;
        int k4, c4, k8, c8;
        bit r4, s4, l4, m4, r8, s8, l8, m8;

        // reset+start together (start dropped), then lsb 1,0,1,1
        tbl.push_back(mk(1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2, 4));
        tbl.push_back(mk(0, 0, 1, 3, 4));
        tbl.push_back(mk(0, 0, 0, 3, 3));
        tbl.push_back(mk(0, 0, 1, 3, 2));
        tbl.push_back(mk(0, 0, 1, 3, 1));
        tbl.push_back(mk(0, 0, 0, 7, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0));
        // start pulsed during EXEC is ignored
        tbl.push_back(mk(0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2, 4));
        tbl.push_back(mk(0, 0, 0, 3, 4));
        tbl.push_back(mk(0, 1, 1, 3, 3));
        tbl.push_back(mk(0, 1, 0, 3, 2));
        tbl.push_back(mk(0, 0, 1, 3, 1));
        tbl.push_back(mk(0, 0, 0, 7, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0));
        // reset at cycle 4 aborts, no done, then a clean restart
        tbl.push_back(mk(0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2, 4));
        tbl.push_back(mk(0, 0, 1, 3, 4));
        tbl.push_back(mk(1, 0, 1, 3, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2, 4));
        tbl.push_back(mk(0, 0, 0, 3, 4));
        tbl.push_back(mk(0, 0, 0, 3, 3));
        tbl.push_back(mk(0, 0, 1, 3, 2));
        tbl.push_back(mk(0, 0, 0, 3, 1));
        tbl.push_back(mk(0, 0, 0, 7, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0));

        reset_all();
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst4 = tbl[i].rst;
            bus4.start = tbl[i].start;
            bus4.lsb = tbl[i].lsb;
            bus4.mult_zero = 1'b0;
            #1;
            check($sformatf("tbl%0d_outs", i), 32'(act4), 32'(exp_out(4, tbl[i].k, tbl[i].lsb)));
            check($sformatf("tbl%0d_cnt", i), 32'(bus4.iter_cnt), 32'(tbl[i].cnt));
        end

        // WIDTH=8, start held high: done at 11, 23, 35; ready in between
        reset_all();
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            rst8 = 1'b0;
            bus8.start = 1'b1;
            bus8.lsb = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("held_done_c%0d", c), 32'(bus8.done),
                  32'((c == 11) || (c == 23) || (c == 35)));
            check($sformatf("held_ready_c%0d", c), 32'(bus8.ready),
                  32'((c == 0) || (c == 12) || (c == 24) || (c == 36)));
        end

        // WIDTH=8, mult_zero during second EXEC cycle
        reset_all();
        first_done = -1;
        cnt_at_done = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            rst8 = 1'b0;
            bus8.start = (c == 0);
            bus8.mult_zero = (c == 4);
            bus8.lsb = 1'($urandom_range(0, 1));
            #1;
            if (bus8.done && (first_done < 0)) begin
                first_done = c;
                cnt_at_done = int'(bus8.iter_cnt);
            end
        end
        check("early_done_cycle", 32'(first_done), EARLY ? 32'd5 : 32'd11);
        check("early_cnt_at_done", 32'(cnt_at_done), EARLY ? 32'd6 : 32'd0);

        // random stimulus on both instances against the phase model
        reset_all();
        k4 = 0; c4 = 0; k8 = 0; c8 = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            r4 = ($urandom_range(0, 31) == 0);
            s4 = ($urandom_range(0, 2) == 0);
            l4 = 1'($urandom_range(0, 1));
            m4 = ($urandom_range(0, 7) == 0);
            r8 = ($urandom_range(0, 31) == 0);
            s8 = ($urandom_range(0, 2) == 0);
            l8 = 1'($urandom_range(0, 1));
            m8 = ($urandom_range(0, 7) == 0);
            rst4 = r4; bus4.start = s4; bus4.lsb = l4; bus4.mult_zero = m4;
            rst8 = r8; bus8.start = s8; bus8.lsb = l8; bus8.mult_zero = m8;
            #1;
            check($sformatf("rnd4_outs_n%0d", n), 32'(act4), 32'(exp_out(4, k4, l4)));
            check($sformatf("rnd4_cnt_n%0d", n), 32'(bus4.iter_cnt), 32'(c4));
            check($sformatf("rnd8_outs_n%0d", n), 32'(act8), 32'(exp_out(8, k8, l8)));
            check($sformatf("rnd8_cnt_n%0d", n), 32'(bus8.iter_cnt), 32'(c8));
            model_step(4, r4, s4, m4, k4, c4, k4, c4);
            model_step(8, r8, s8, m8, k8, c8, k8, c8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_mult_ctrl.md
# seq_mult_ctrl

Parametrised control unit for the sequential shift-add multiplier. It replaces the fixed 4×4 controller with a WIDTH-bit version that has an explicit start/ready handshake, an iteration counter and a one-cycle `done` pulse. It drives the datapath's clear, load, shift and add-select strobes. The datapath uses a left-shifting multiplicand, a right-shifting multiplier and a 2·WIDTH accumulator that is never shifted.

## Interface
- `WIDTH`, default 4: operand width; number of EXEC iterations (≥2).
- `CNT_W`, default `$clog2(WIDTH+1)`: iteration counter width; derived, do not override.

- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a multiply; sampled only in IDLE.
- `lsb` in 1: current multiplier bit 0 from the datapath.
- `mult_zero` in 1: remaining multiplier bits all zero (used only with the macro).
- `ready` out 1: idle and accepting `start`.
- `busy` out 1: equals `~ready`.
- `sig_rst` out 1: clear accumulator.
- `ld1` out 1: load multiplicand and multiplier registers.
- `ld2` out 1: accumulator write enable.
- `sel_add` out 1: accumulator source; 1 selects acc+multiplicand, 0 holds acc.
- `shift` out 1: shift multiplicand left 1 and multiplier right 1.
- `done` out 1: one-cycle pulse; product valid in the accumulator.
- `iter_cnt` out CNT_W: remaining iterations.

## Operation
- FSM states: IDLE, CLEAR, LOAD, EXEC, DONE. Binary encoding; registered state; outputs are a Moore decode of state plus `lsb`.
- **IDLE:**
  - `ready`=1; all strobes 0.
  - `start`=1 → CLEAR. Otherwise stay in IDLE.
- **CLEAR:**
  - `sig_rst`=1.
  - `iter_cnt` ← WIDTH.
  - → LOAD.
- **LOAD:**
  - `ld1`=1.
  - → EXEC.
- **EXEC:**
  - `ld2`=1, `shift`=1, `sel_add`=`lsb`.
  - `iter_cnt` ← `iter_cnt`−1.
  - When `iter_cnt`==1 → DONE; otherwise stay in EXEC.
- **DONE:**
  - `done`=1; `ld2`=0, `shift`=0.
  - → IDLE unconditionally.
- `start` outside IDLE is ignored and not queued.
- `start` held high continuously starts a new operation on every IDLE cycle.
- `iter_cnt` saturates at 0 and never wraps.
- `lsb` and `mult_zero` are don't-care outside EXEC.

## Timing
- Reset values:
  - state=IDLE, `iter_cnt`=0, `ready`=1, `busy`=0.
  - `sig_rst`, `ld1`, `ld2`, `sel_add`, `shift`, `done` all 0.
- `rst` in any state returns the FSM to IDLE on the next edge. No `done` is issued for the aborted operation.
- `rst` and `start` in the same cycle: reset wins; `start` is dropped.
- Start accepted at edge 0. Cycle sequence:
  - CLEAR at cycle 1.
  - LOAD at cycle 2.
  - EXEC at cycles 3 … WIDTH+2.
  - DONE at cycle WIDTH+3.
  - `ready` at cycle WIDTH+4.
- Total latency from `start` to `done` is WIDTH+3 cycles. Back-to-back throughput is one product per WIDTH+4 cycles.
- `done` and `ready` are never high in the same cycle.

## Configuration
- `SEQ_MULT_CTRL_EARLY_TERM_EN` defined:
  - In EXEC, `mult_zero`=1 forces → DONE on the next edge regardless of `iter_cnt`.
  - That EXEC cycle still asserts `ld2`/`shift`, and `iter_cnt` still decrements.
  - The result is correct because the accumulator is not shifted.
  - Latency becomes 4 + (index of highest set multiplier bit) cycles; minimum 4.
- Macro undefined:
  - `mult_zero` is ignored and the input remains present but unused.
  - Latency is always WIDTH+3.

## Test plan
- WIDTH=4, reset released, pulse `start` with `lsb` pattern 1,0,1,1:
  - `sig_rst` at cycle 1, `ld1` at cycle 2.
  - `sel_add`=1,0,1,1 at cycles 3–6.
  - `done` at cycle 7, `ready` at cycle 8.
- WIDTH=4, pulse `start` again during EXEC: no effect; `done` still at cycle 7; exactly one `done`.
- WIDTH=4, assert `rst` at cycle 4 (mid-EXEC):
  - Next cycle state=IDLE, `iter_cnt`=0, `ready`=1.
  - No `done` pulse.
  - A new `start` then completes normally.
- WIDTH=8, `start` held high continuously: `done` at cycles 11, 23, 35, each one cycle wide, with `ready` for one cycle in between.
- With the macro defined, WIDTH=8, `mult_zero`=1 during the second EXEC cycle: `done` at cycle 5, `iter_cnt`=6 at DONE.
- Without the macro, the same stimulus gives `done` at cycle 11.
